// File: rtl/ysyx_23060061_clint.sv
// Core-local timer: free-running 64-bit mtime, read-only AXI4 single-beat slave.
// Optional YSYX_23060061_CLINT_SHADOW_EN: a low-word read latches the high word for a coherent pair.
module ysyx_23060061_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned DIV       = 1
) (
  input  logic        clk,
  input  logic        rst,
  // read address / data
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  output logic [3:0]  rid,
  // write address / data / response
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  input  logic        wlast,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_RESP = 1'b1;
  localparam logic W_IDLE = 1'b0;
  localparam logic W_RESP = 1'b1;

  // ---------------------------------------------------------------------------
  // mtime and prescaler
  // ---------------------------------------------------------------------------
  logic [63:0]   mtime_q, mtime_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic        r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [3:0]  rid_q, rid_d;
  logic        ar_fire;
  logic        ar_bad;
  logic [31:0] hi_word;

  assign ar_fire = arvalid && arready;
  assign ar_bad  = (arlen != 8'd0) || (arsize > 3'b010);

`ifdef YSYX_23060061_CLINT_SHADOW_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (ar_fire && (araddr[3:0] == 4'h0)) begin
      shadow_q <= mtime_q[63:32];
    end
  end

  assign hi_word = shadow_q;
`else
  assign hi_word = mtime_q[63:32];
`endif

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_RESP;
          rid_d     = arid;
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          if (!ar_bad) begin
            case (araddr[3:0])
              4'h0: begin
                rdata_d = mtime_q[31:0];
                rresp_d = RESP_OKAY;
              end
              4'h4: begin
                rdata_d = hi_word;
                rresp_d = RESP_OKAY;
              end
              default: ;
            endcase
          end
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rlast   = rvalid;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;

  // ---------------------------------------------------------------------------
  // Write channel: accepts AW and W in any order, always answers SLVERR
  // ---------------------------------------------------------------------------
  logic       w_state_q, w_state_d;
  logic       aw_got_q, aw_got_d;
  logic       w_got_q, w_got_d;
  logic [3:0] awid_q, awid_d;
  logic [3:0] bid_q, bid_d;
  logic       aw_fire, w_fire;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awid_d    = awid_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_got_d = 1'b1;
          awid_d   = awid;
        end
        if (w_fire) w_got_d = 1'b1;
        if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) begin
          w_state_d = W_RESP;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          bid_d     = aw_fire ? awid : awid_q;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awid_q    <= '0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awid_q    <= awid_d;
      bid_q     <= bid_d;
    end
  end

  assign awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign wready  = (w_state_q == W_IDLE) && !w_got_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bvalid ? RESP_SLVERR : RESP_OKAY;
  assign bid     = bid_q;

  // Window decode is done by the crossbar; these inputs carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{BASE_ADDR, araddr[31:4], arburst, awaddr, awlen, awsize, awburst,
                           wdata, wstrb, wlast};

endmodule

// File: tb/tb_ysyx_23060061_clint.sv
// Directed bench for ysyx_23060061_clint: one DIV=1 instance, one DIV=4 instance.
module tb_ysyx_23060061_clint;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  // DIV=1 instance signals
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wlast, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  bid;

  // DIV=4 instance signals
  logic [31:0] araddr4;
  logic        arvalid4, arready4;
  logic [3:0]  arid4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4;
  logic        rvalid4, rready4, rlast4;
  logic [3:0]  rid4;
  logic        awready4, wready4;
  logic [1:0]  bresp4;
  logic        bvalid4;
  logic [3:0]  bid4;

  ysyx_23060061_clint #(.DIV(1)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready), .rlast(rlast), .rid(rid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wlast(wlast), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bid(bid)
  );

  ysyx_23060061_clint #(.DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .araddr(araddr4), .arvalid(arvalid4), .arready(arready4), .arid(arid4), .arlen(8'd0),
    .arsize(3'b010), .arburst(2'b01), .rdata(rdata4), .rresp(rresp4), .rvalid(rvalid4),
    .rready(rready4), .rlast(rlast4), .rid(rid4),
    .awaddr(32'd0), .awvalid(1'b0), .awready(awready4), .awid(4'd0), .awlen(8'd0),
    .awsize(3'd0), .awburst(2'd0), .wdata(32'd0), .wstrb(4'd0), .wvalid(1'b0),
    .wlast(1'b0), .wready(wready4), .bresp(bresp4), .bvalid(bvalid4), .bready(1'b1),
    .bid(bid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of mtime for the DIV=1 instance: edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one read on the DIV=1 instance with rready held high; call just after a posedge.
  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    araddr  = addr;
    arid    = id;
    arlen   = len;
    arsize  = size;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    arlen   = 8'd0;
    arsize  = 3'b010;
    check_eq({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    check_eq({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
    check_eq({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
    check_eq({tag, "_rlast"}, 64'(rlast), 64'd1);
    check_eq({tag, "_rid"}, 64'(rid), 64'(id));
    check_eq({tag, "_arready_busy"}, 64'(arready), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_rvalid_done"}, 64'(rvalid), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_hi;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    araddr = '0; arvalid = 0; arid = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
    rready = 1'b1;
    awaddr = '0; awvalid = 0; awid = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01;
    wdata = '0; wstrb = 4'hF; wvalid = 0; wlast = 1'b1; bready = 1'b0;
    araddr4 = '0; arvalid4 = 0; arid4 = '0; rready4 = 1'b1;

    #3;
    check_eq("rst_arready", 64'(arready), 64'd1);
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    check_eq("rst_rresp", 64'(rresp), 64'd0);
    check_eq("rst_rlast", 64'(rlast), 64'd0);
    check_eq("rst_rid", 64'(rid), 64'd0);
    check_eq("rst_awready", 64'(awready), 64'd1);
    check_eq("rst_wready", 64'(wready), 64'd1);
    check_eq("rst_bvalid", 64'(bvalid), 64'd0);
    check_eq("rst_bresp", 64'(bresp), 64'd0);
    check_eq("rst_bid", 64'(bid), 64'd0);

    @(negedge clk);
    rst = 1'b0;

    // DIV=1: accepted at the edge where mtime is 10
    while (cyc < 10) begin @(posedge clk); #1; end
    read_chk("rd_c10", 32'h0200_0000, 4'h5, 8'd0, 3'b010, 32'd10, 2'b00);

    // DIV=4: 40 edges -> mtime 10; hold rready low and watch stability
    while (cyc < 40) begin @(posedge clk); #1; end
    rready4  = 1'b0;
    araddr4  = 32'h0200_0000;
    arid4    = 4'hA;
    arvalid4 = 1'b1;
    @(posedge clk); #1;
    arvalid4 = 1'b0;
    check_eq("d4_rvalid", 64'(rvalid4), 64'd1);
    check_eq("d4_rdata", 64'(rdata4), 64'd10);
    check_eq("d4_rid", 64'(rid4), 64'hA);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("d4_hold_rvalid", 64'(rvalid4), 64'd1);
      check_eq("d4_hold_rdata", 64'(rdata4), 64'd10);
      check_eq("d4_hold_arready", 64'(arready4), 64'd0);
    end
    rready4 = 1'b1;
    @(posedge clk); #1;
    check_eq("d4_rvalid_done", 64'(rvalid4), 64'd0);
    check_eq("d4_arready_back", 64'(arready4), 64'd1);

    // Error decodes
    read_chk("rd_off8", 32'h0200_0008, 4'h1, 8'd0, 3'b010, 32'd0, 2'b10);
    read_chk("rd_len1", 32'h0200_0000, 4'h2, 8'd1, 3'b010, 32'd0, 2'b10);
    read_chk("rd_size3", 32'h0200_0004, 4'h4, 8'd0, 3'b011, 32'd0, 2'b10);
    read_chk("rd_hi_live", 32'h0200_0004, 4'h6, 8'd0, 3'b010, 32'd0, 2'b00);

    // Write: W two cycles before AW
    wdata  = 32'hDEAD_BEEF;
    wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check_eq("wr_wready_drop", 64'(wready), 64'd0);
    check_eq("wr_awready_open", 64'(awready), 64'd1);
    check_eq("wr_bvalid_early", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    check_eq("wr_wready_stay", 64'(wready), 64'd0);
    awid    = 4'h3;
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check_eq("wr_bvalid", 64'(bvalid), 64'd1);
    check_eq("wr_bresp", 64'(bresp), 64'd2);
    check_eq("wr_bid", 64'(bid), 64'd3);
    check_eq("wr_awready_busy", 64'(awready), 64'd0);
    @(posedge clk); #1;
    check_eq("wr_bvalid_hold", 64'(bvalid), 64'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_eq("wr_bvalid_done", 64'(bvalid), 64'd0);
    check_eq("wr_awready_back", 64'(awready), 64'd1);
    check_eq("wr_wready_back", 64'(wready), 64'd1);
    read_chk("rd_after_wr", 32'h0200_0000, 4'h7, 8'd0, 3'b010, cyc[31:0], 2'b00);

    // Carry across the word boundary
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.mtime_q;
`ifdef YSYX_23060061_CLINT_SHADOW_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    read_chk("carry_lo", 32'h0200_0000, 4'h8, 8'd0, 3'b010, 32'hFFFF_FFFE, 2'b00);
    read_chk("carry_hi", 32'h0200_0004, 4'h9, 8'd0, 3'b010, exp_hi, 2'b00);

    // 64-bit wrap
    force dut.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.mtime_q;
    @(posedge clk); #1;
    read_chk("wrap_lo", 32'h0200_0000, 4'hB, 8'd0, 3'b010, 32'd0, 2'b00);
    read_chk("wrap_hi", 32'h0200_0004, 4'hC, 8'd0, 3'b010, 32'd0, 2'b00);

    // Asynchronous reset while a response is pending
    rready  = 1'b0;
    araddr  = 32'h0200_0000;
    arid    = 4'hD;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_eq("ar_pend_rvalid", 64'(rvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("ar_rst_arready", 64'(arready), 64'd1);
    check_eq("ar_rst_rid", 64'(rid), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    rready = 1'b1;
    read_chk("rd_post_rst", 32'h0200_0000, 4'hE, 8'd0, 3'b010, 32'd0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
